snn_stim_tx: RTL and testbench
==============================

# snn_stim_tx

Transmit-side driver for the SNN inference core. It holds one frame of configuration: two 6x6 images, a 3x3 kernel and 4 FC weights, loaded over a simple byte-write port. On `start` it streams the frame as a single 72-beat `in_valid` burst, in the exact order the core consumes it. It then waits for the core's one-cycle `out_valid` result pulse, captures `out_data`, and reports completion or timeout. It sits between the test or host controller and the SNN core's input and output ports.

## Interface
- `TIMEOUT`, default 255: maximum number of WAIT cycles without `out_valid` before the transaction is aborted. Legal range is 1..1023.
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `cfg_we`  in  1  Frame-buffer byte write strobe.
- `cfg_addr`  in  7  Frame-buffer byte address:
  - 0..35: image 1, row-major.
  - 36..71: image 2, row-major.
  - 72..80: kernel k0..k8.
  - 81..84: weights w0..w3.
  - 85..127: ignored.
- `cfg_wdata`  in  8  Write data.
- `start`  in  1  Begin a transaction; accepted only in IDLE.
- `busy`  out  1  High in SEND and WAIT.
- `in_valid`  out  1  Burst valid to the core.
- `img`  out  8  Pixel to the core.
- `ker`  out  8  Kernel byte to the core.
- `weight`  out  8  Weight byte to the core.
- `out_valid`  in  1  Result strobe from the core.
- `out_data`  in  10  Result from the core.
- `done`  out  1  One-cycle completion pulse.
- `result`  out  10  Captured `out_data`; held until the next accepted `start`.
- `timeout_err`  out  1  Error flag for the most recent transaction; held until the next accepted `start`.

## Operation
- **Frame buffer.** 85 bytes with no reset; contents survive `rst`.
  - A write takes effect at the edge where `cfg_we` is sampled high.
  - Writes are ignored while `busy`=1. Addresses 85..127 are ignored.
- **State machine.** States are IDLE, SEND, WAIT.
- **IDLE → SEND** on `start`=1.
  - The beat counter clears to 0.
  - `timeout_err` clears to 0 and `result` clears to 0.
- **SEND.** Beat counter b runs 0..71; one beat per cycle with no gaps.
  - `in_valid`=1.
  - `img` = buffer[b].
  - `ker` = buffer[72+b] for b≤8, else 0.
  - `weight` = buffer[81+b] for b≤3, else 0.
  - After b=71 the next state is WAIT and the wait counter clears to 0.
- **WAIT.**
  - `in_valid`=0 and the data outputs are 0.
  - The wait counter increments every cycle, saturating at `TIMEOUT`.
  - If `out_valid`=1 is sampled: `result` ← `out_data`, `done` pulses, and the next state is IDLE.
  - If the wait counter equals `TIMEOUT`-1 and `out_valid`=0: `timeout_err` ← 1, `result` ← 0, `done` pulses, and the next state is IDLE.
- **`out_valid` outside WAIT** (IDLE or SEND) is ignored: no capture and no state change.
- **Start handling.** `start` while `busy`=1 is ignored. `start` in the same cycle as `done`=1 is accepted, because the FSM is already in IDLE.
- **Simultaneous `cfg_we` and `start` in IDLE.** The write lands first. Beat 0 is read from the buffer after the edge, so it reflects the write.

## Timing
- All outputs are registered.
- **Reset values:** `busy`=0, `in_valid`=0, `img`=0, `ker`=0, `weight`=0, `done`=0, `result`=0, `timeout_err`=0; state is IDLE.
- **Reset mid-transaction:** in the cycle after `rst` is sampled, all outputs are at their reset values and `in_valid` drops immediately, giving a truncated burst. A later `start` resends the full burst.
- **Start latency:** `start` sampled high in cycle c gives `in_valid`=1 in cycles c+1..c+72, carrying beat b in cycle c+1+b.
- **`busy` window:** `busy`=1 from cycle c+1 until the cycle before `done`. In the `done` cycle `busy`=0.
- **Result latency:** `out_valid` high in WAIT cycle w gives `done`=1 and the new `result` in cycle w+1.
- **Timeout:** the first WAIT cycle is c+73. If `out_valid` never arrives, `done` and `timeout_err` are both 1 in cycle c+73+`TIMEOUT`.
- **Throughput:** one transaction at a time. The minimum transaction period is 74 cycles (start→SEND 72→WAIT 1→IDLE), assuming `out_valid` arrives in the first WAIT cycle.

## Test plan
- **Full-burst ordering.** Load buffer[a]=a for a=0..84, then pulse `start`.
  - Expect exactly 72 consecutive `in_valid` cycles with `img`=0..71.
  - Expect `ker`=72..80 on beats 0..8, then 0.
  - Expect `weight`=81..84 on beats 0..3, then 0.
- **Result capture.** After the burst, drive `out_valid`=1 with `out_data`=10'h2A5 in WAIT cycle 5.
  - Expect `done`=1 and `result`=0x2A5 one cycle later, with `busy`=0 and `timeout_err`=0.
- **Timeout.** Use `TIMEOUT`=8 and never raise `out_valid`.
  - Expect `done` and `timeout_err`=1 at cycle c+81 with `result`=0.
  - A following `start` clears `timeout_err` to 0.
- **Ignored inputs during SEND.** Assert `start` and `cfg_we` (addr 0, data 0xFF) at beat 10, and `out_valid`=1 at beat 20.
  - Expect the burst to be unchanged and no `done`.
  - Expect buffer[0] still to read 0 on the next transaction.
- **Reset mid-burst.** Assert `rst` at beat 30.
  - Expect `in_valid`=0 next cycle and all outputs at reset values.
  - Re-`start` must replay the original buffer contents in full, proving the buffer is not reset.
- **Back-to-back.** Assert `start` in the `done` cycle.
  - Expect the second burst to begin in the next cycle, with `result` cleared to 0 at the same time.

Source files
------------

// File: rtl/snn_stim_tx.sv
// Transmit-side driver for the SNN core: holds one 85-byte frame, streams it as a
// 72-beat burst on start, then waits for the core's result or a timeout.
module snn_stim_tx #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [6:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       start,
  output logic       busy,
  output logic       in_valid,
  output logic [7:0] img,
  output logic [7:0] ker,
  output logic [7:0] weight,
  input  logic       out_valid,
  input  logic [9:0] out_data,
  output logic       done,
  output logic [9:0] result,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [9:0] TO_MAX  = 10'(TIMEOUT);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
  localparam logic [6:0] LAST_BEAT = 7'd71;

  state_t     state;
  logic [6:0] beat;
  logic [9:0] wait_cnt;
  logic [7:0] mem [85];

  logic       wr_en;
  logic [6:0] nb;
  logic [7:0] first_img, first_ker, first_weight;
  logic [7:0] next_img, next_ker, next_weight;

  assign wr_en = cfg_we && !busy && (cfg_addr < 7'd85);

  // Frame buffer deliberately has no reset so a frame survives an aborted transaction.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cfg_addr] <= cfg_wdata;
  end

  // Beat 0 is loaded at the start edge, so a same-edge write is forwarded into it.
  always_comb begin
    nb           = beat + 7'd1;
    first_img    = (wr_en && cfg_addr == 7'd0)  ? cfg_wdata : mem[0];
    first_ker    = (wr_en && cfg_addr == 7'd72) ? cfg_wdata : mem[72];
    first_weight = (wr_en && cfg_addr == 7'd81) ? cfg_wdata : mem[81];
    next_img     = mem[nb];
    next_ker     = (nb <= 7'd8) ? mem[7'd72 + nb] : 8'd0;
    next_weight  = (nb <= 7'd3) ? mem[7'd81 + nb] : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      beat        <= 7'd0;
      wait_cnt    <= 10'd0;
      busy        <= 1'b0;
      in_valid    <= 1'b0;
      img         <= 8'd0;
      ker         <= 8'd0;
      weight      <= 8'd0;
      done        <= 1'b0;
      result      <= 10'd0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_SEND;
            beat        <= 7'd0;
            busy        <= 1'b1;
            in_valid    <= 1'b1;
            img         <= first_img;
            ker         <= first_ker;
            weight      <= first_weight;
            result      <= 10'd0;
            timeout_err <= 1'b0;
          end
        end
        S_SEND: begin
          if (beat == LAST_BEAT) begin
            state    <= S_WAIT;
            wait_cnt <= 10'd0;
            in_valid <= 1'b0;
            img      <= 8'd0;
            ker      <= 8'd0;
            weight   <= 8'd0;
          end else begin
            beat   <= nb;
            img    <= next_img;
            ker    <= next_ker;
            weight <= next_weight;
          end
        end
        S_WAIT: begin
          if (wait_cnt != TO_MAX) wait_cnt <= wait_cnt + 10'd1;
          // A result arriving on the final wait cycle still wins over the timeout.
          if (out_valid) begin
            result <= out_data;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            result      <= 10'd0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_stim_tx.sv
// Randomized bench for snn_stim_tx: a frame-level model predicts every burst beat,
// the result/timeout outcome and the held status outputs.
module tb_snn_stim_tx;

  localparam int TO = 8;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [6:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       start;
  logic       busy;
  logic       in_valid;
  logic [7:0] img;
  logic [7:0] ker;
  logic [7:0] weight;
  logic       out_valid;
  logic [9:0] out_data;
  logic       done;
  logic [9:0] result;
  logic       timeout_err;

  snn_stim_tx #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .busy(busy), .in_valid(in_valid), .img(img), .ker(ker),
    .weight(weight), .out_valid(out_valid), .out_data(out_data), .done(done),
    .result(result), .timeout_err(timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  ref_mem [85];
  logic [9:0]  exp_result;
  logic        exp_terr;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected burst straight from the frame layout: image bytes 0..71, kernel bytes on
  // the first 9 beats, weights on the first 4 beats.
  task automatic build_expected();
    exp_q.delete();
    for (int b = 0; b < 72; b++) begin
      exp_q.push_back({ref_mem[b],
                       (b < 9) ? ref_mem[72 + b] : 8'd0,
                       (b < 4) ? ref_mem[81 + b] : 8'd0});
    end
  endtask

  // driver tasks: every task is entered and left at a falling edge
  task automatic cfg_write(input logic [6:0] addr, input logic [7:0] data);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_wdata = data;
    if (addr < 7'd85) ref_mem[addr] = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", {done, busy, in_valid, timeout_err, result},
            {3'b000, exp_terr, exp_result});
      out_valid = 1'($urandom_range(0, 1));
      out_data = 10'($urandom);
    end
  endtask

  // reply_at < 0 means the core never answers
  task automatic run_txn(input int reply_at, input logic [9:0] rdata, input bit inject,
                         input int rst_beat, input bit wr_start,
                         input logic [6:0] wr_addr, input logic [7:0] wr_val);
    logic [23:0] exp;
    int last;
    start = 1'b1;
    if (wr_start) begin
      cfg_we = 1'b1;
      cfg_addr = wr_addr;
      cfg_wdata = wr_val;
      if (wr_addr < 7'd85) ref_mem[wr_addr] = wr_val;
    end
    build_expected();
    exp_result = 10'd0;
    exp_terr = 1'b0;
    for (int b = 0; b < 72; b++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_we = 1'b0;
      out_valid = 1'b0;
      exp = exp_q.pop_front();
      check("beat", {in_valid, busy, done, img, ker, weight}, {3'b110, exp});
      if (b == 0) check("start_clr", {result, timeout_err}, 64'd0);
      if (inject && b == 10) begin
        start = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = 7'd0;
        cfg_wdata = 8'hFF;
      end
      if (inject && b == 20) begin
        out_valid = 1'b1;
        out_data = 10'($urandom);
      end
      if (b == rst_beat) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", {busy, in_valid, img, ker, weight, done, result, timeout_err}, 64'd0);
        exp_result = 10'd0;
        exp_terr = 1'b0;
        return;
      end
    end
    last = (reply_at < 0) ? TO - 1 : reply_at;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      out_valid = 1'b0;
      check("wait", {in_valid, busy, done, img, ker, weight}, {3'b010, 24'd0});
      if (k == reply_at) begin
        out_valid = 1'b1;
        out_data = rdata;
      end
    end
    @(negedge clk);
    out_valid = 1'b0;
    if (reply_at < 0) begin
      exp_result = 10'd0;
      exp_terr = 1'b1;
    end else begin
      exp_result = rdata;
      exp_terr = 1'b0;
    end
    check("done", {done, busy, in_valid, timeout_err, result}, {3'b100, exp_terr, exp_result});
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = 7'd0;
    cfg_wdata = 8'd0;
    start = 1'b0;
    out_valid = 1'b0;
    out_data = 10'd0;
    exp_result = 10'd0;
    exp_terr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", {busy, in_valid, img, ker, weight, done, result, timeout_err}, 64'd0);
    rst = 1'b0;

    // ordered frame, result in wait cycle 5
    for (int a = 0; a < 85; a++) cfg_write(7'(a), 8'(a));
    idle(2);
    run_txn(5, 10'h2A5, 1'b0, -1, 1'b0, 7'd0, 8'd0);
    idle(3);

    // timeout, then a start that must clear the error
    run_txn(-1, 10'd0, 1'b0, -1, 1'b0, 7'd0, 8'd0);
    idle(2);

    // start/write/out_valid during SEND ignored; buffer[0] still 0 on the next burst
    run_txn(int'($urandom_range(0, TO - 1)), 10'($urandom), 1'b1, -1, 1'b0, 7'd0, 8'd0);
    idle(1);

    // reset mid-burst, then full replay of the unchanged frame
    run_txn(0, 10'd0, 1'b0, 30, 1'b0, 7'd0, 8'd0);
    idle(2);
    run_txn(int'($urandom_range(0, TO - 1)), 10'($urandom), 1'b0, -1, 1'b0, 7'd0, 8'd0);

    // back-to-back with a write landing on the start edge
    run_txn(0, 10'($urandom), 1'b0, -1, 1'b1, 7'd0, 8'($urandom));
    run_txn(TO - 1, 10'($urandom), 1'b0, -1, 1'b1, 7'd81, 8'($urandom));
    idle(2);

    // randomized frames and outcomes
    for (int it = 0; it < 5; it++) begin
      for (int w = 0; w < 8; w++) cfg_write(7'($urandom_range(0, 127)), 8'($urandom));
      run_txn(($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1)),
              10'($urandom), 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)),
              7'($urandom_range(0, 84)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
